// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared constants and FSM state type for the PUF CRP sequencer
//
// Purpose: default challenge width, default LFSR feedback mask and the
// sequencer state enum, shared by puf_lfsr and puf_crp_sequencer.
// Ports: none (package).
package puf_pkg;

  localparam int          C_LENGTH_DEFAULT = 8;
  // Fibonacci feedback mask; maximal length (period 255) for 8 bits.
  localparam logic [7:0]  TAPS_DEFAULT     = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_HIGH   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_OUT    = 3'd4
  } crp_state_t;

endpackage

// File: rtl/puf_lfsr.sv
// rtl/puf_lfsr.sv - loadable/steppable Fibonacci LFSR for PUF challenges
//
// Purpose: holds the current challenge. A load takes seed (an all-zero seed
// is replaced by 1 so the register never locks up); a step shifts left and
// feeds back the parity of the tapped bits into bit 0.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (value -> 0)
//   load  in   load seed (takes priority over step)
//   step  in   advance one LFSR step
//   seed  in   C_LENGTH load value
//   value out  C_LENGTH current LFSR contents
module puf_lfsr
  import puf_pkg::*;
#(
  parameter int                   C_LENGTH = C_LENGTH_DEFAULT,
  parameter logic [C_LENGTH-1:0]  TAPS     = C_LENGTH'(TAPS_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [C_LENGTH-1:0] seed,
  output logic [C_LENGTH-1:0] value
);

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == '0) ? C_LENGTH'(1) : seed;
    end else if (step) begin
      value <= {value[C_LENGTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/puf_crp_sequencer.sv
// rtl/puf_crp_sequencer.sv - challenge generator, majority voter and CRP stream for the arbiter PUF
//
// Purpose: for each challenge, runs NVOTE evaluations (LOW phase, HIGH race
// pulse phase, one SAMPLE cycle), majority-votes the synchronized response
// and presents the challenge/response pair on a ready/valid stream.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   start         in   begin a run (honoured only in IDLE)
//   seed          in   C_LENGTH initial LFSR value (0 -> 1)
//   count         in   8  number of CRPs in the run (0 = empty run)
//   challenge_o   out  C_LENGTH challenge driven into the PUF
//   pulse_o       out  race pulse into the PUF (registered)
//   response_i    in   RESP_W PUF response, asynchronous to clk
//   out_valid     out  CRP available
//   out_ready     in   consumer accepts the CRP
//   out_challenge out  C_LENGTH challenge of the presented CRP
//   out_response  out  RESP_W voted response of the presented CRP
//   busy          out  FSM not in IDLE
//   done          out  one-cycle pulse at the end of a run
module puf_crp_sequencer
  import puf_pkg::*;
#(
  parameter int                   C_LENGTH = C_LENGTH_DEFAULT,
  parameter int                   RESP_W   = 8,
  parameter logic [C_LENGTH-1:0]  TAPS     = C_LENGTH'(TAPS_DEFAULT),
  parameter int                   NVOTE    = 5,
  parameter int                   SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [C_LENGTH-1:0] seed,
  input  logic [7:0]          count,
  output logic [C_LENGTH-1:0] challenge_o,
  output logic                pulse_o,
  input  logic [RESP_W-1:0]   response_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [C_LENGTH-1:0] out_challenge,
  output logic [RESP_W-1:0]   out_response,
  output logic                busy,
  output logic                done
);

  localparam int VW = $clog2(NVOTE + 1);
  localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  crp_state_t          state, next_state;
  logic [PW-1:0]       phase;
  logic [VW-1:0]       eval_idx;
  logic [VW-1:0]       votes [RESP_W];
  logic [7:0]          remaining;
  logic [RESP_W-1:0]   sync1, sync2;
  logic [C_LENGTH-1:0] lfsr_value;

  logic start_accept;
  logic handshake;
  logic phase_last;
  logic run_last;

  puf_lfsr #(
    .C_LENGTH (C_LENGTH),
    .TAPS     (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_accept),
    .step  (handshake),
    .seed  (seed),
    .value (lfsr_value)
  );

  assign challenge_o = lfsr_value;
  assign busy        = (state != ST_IDLE);
  assign out_valid   = (state == ST_OUT);
  assign phase_last  = (phase == PW'(SETTLE - 1));
  assign run_last    = (remaining == 8'd1);

  // Two-flop synchronizer; the PUF response is not timed against clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= response_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    handshake    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          if (count != 8'd0) next_state = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_last) next_state = ST_HIGH;
      end
      ST_HIGH: begin
        if (phase_last) next_state = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // eval_idx still holds the pre-increment value here.
        if (eval_idx == VW'(NVOTE - 1)) next_state = ST_OUT;
        else                            next_state = ST_LOW;
      end
      ST_OUT: begin
        if (out_ready) begin
          handshake  = 1'b1;
          next_state = run_last ? ST_IDLE : ST_LOW;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Phase counter runs only in LOW/HIGH and is zero everywhere else, so each
  // phase starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if ((state == ST_LOW || state == ST_HIGH) && !phase_last) begin
      phase <= phase + PW'(1);
    end else begin
      phase <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eval_idx  <= '0;
      remaining <= '0;
      for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
    end else if (start_accept) begin
      eval_idx  <= '0;
      remaining <= count;
      for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
    end else if (state == ST_SAMPLE) begin
      eval_idx <= eval_idx + VW'(1);
      for (int b = 0; b < RESP_W; b++) votes[b] <= votes[b] + VW'(sync2[b]);
    end else if (handshake) begin
      eval_idx  <= '0;
      remaining <= remaining - 8'd1;
      for (int b = 0; b < RESP_W; b++) votes[b] <= '0;
    end
  end

  // pulse_o follows the state being entered, so it is high exactly while the
  // FSM sits in HIGH and comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_o <= 1'b0;
      done    <= 1'b0;
    end else begin
      pulse_o <= (next_state == ST_HIGH);
      done    <= (start_accept && count == 8'd0) || (handshake && run_last);
    end
  end

  assign out_challenge = out_valid ? lfsr_value : '0;

  always_comb begin
    out_response = '0;
    if (out_valid) begin
      for (int b = 0; b < RESP_W; b++) begin
        out_response[b] = (votes[b] > VW'(NVOTE / 2));
      end
    end
  end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// tb/tb_puf_crp_sequencer.sv - directed self-checking bench for puf_crp_sequencer
module tb_puf_crp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic [7:0] count;
  logic [7:0] challenge_o;
  logic       pulse_o;
  logic [7:0] response_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_challenge;
  logic [7:0] out_response;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // PUF model: mode 0 echoes the challenge; mode 1 returns FF/00 per
  // evaluation from a 5-bit pattern, indexed by completed pulses since pat_base.
  int         mode = 0;
  int         ev = 0;
  int         pat_base = 0;
  logic [4:0] pattern = 5'b0;

  always #5 clk = ~clk;

  always @(negedge pulse_o) ev++;

  always_comb begin
    if (mode == 0) response_i = challenge_o;
    else           response_i = pattern[(ev - pat_base) % 5] ? 8'hFF : 8'h00;
  end

  puf_crp_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seed          (seed),
    .count         (count),
    .challenge_o   (challenge_o),
    .pulse_o       (pulse_o),
    .response_i    (response_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_challenge (out_challenge),
    .out_response  (out_response),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] s, input logic [7:0] c);
    @(negedge clk);
    seed  = s;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_chal"},  challenge_o,   32'h0);
    check({tag, "_pulse"}, pulse_o,       32'h0);
    check({tag, "_valid"}, out_valid,     32'h0);
    check({tag, "_ochal"}, out_challenge, 32'h0);
    check({tag, "_oresp"}, out_response,  32'h0);
    check({tag, "_busy"},  busy,          32'h0);
    check({tag, "_done"},  done,          32'h0);
  endtask

  logic [7:0] exp_a [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  initial begin
    int k, last_n, done_cnt, any_valid, any_pulse, bad;
    logic [7:0] held_c, held_r;

    rst = 1'b1; start = 1'b0; seed = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Echo PUF, six CRPs from seed 01 with ready held high.
    mode = 0;
    start_run(8'h01, 8'd6);
    k = 0; last_n = 0; done_cnt = 0;
    for (int n = 0; n < 400 && done_cnt == 0; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("a_busy", busy, 1);
        check("a_chal_load", challenge_o, 8'h01);
      end
      if (n == 3) check("a_pulse_low", pulse_o, 0);
      if (n == 4) check("a_pulse_high", pulse_o, 1);
      if (out_valid) begin
        if (k == 0) check("a_latency", n, 45);
        if (k == 1) check("a_gap", n - last_n, 46);
        if (k < 6) begin
          check("a_ochal", out_challenge, exp_a[k]);
          check("a_oresp", out_response, exp_a[k]);
        end
        last_n = n;
        k++;
      end
      if (done) begin
        done_cnt++;
        check("a_done_busy", busy, 0);
      end
    end
    check("a_crp_count", k, 6);
    check("a_done_seen", done_cnt, 1);
    @(negedge clk);
    check("a_done_width", done, 0);

    // Empty run.
    start_run(8'h5A, 8'd0);
    @(negedge clk);
    check("b_done", done, 1);
    check("b_busy", busy, 0);
    check("b_chal", challenge_o, 8'h5A);
    any_valid = 0; any_pulse = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid) any_valid++;
      if (pulse_o) any_pulse++;
    end
    check("b_no_valid", any_valid, 0);
    check("b_no_pulse", any_pulse, 0);

    // Zero seed becomes 1.
    start_run(8'h00, 8'd1);
    wait_valid("c_valid");
    check("c_ochal", out_challenge, 8'h01);
    wait_done("c_done");

    // Majority vote: 3 of 5 high -> FF, 2 of 5 high -> 00.
    mode = 1;
    pattern = 5'b10101;
    pat_base = ev;
    start_run(8'h33, 8'd1);
    wait_valid("d1_valid");
    check("d1_oresp", out_response, 8'hFF);
    wait_done("d1_done");
    pattern = 5'b01010;
    pat_base = ev;
    start_run(8'h33, 8'd1);
    wait_valid("d2_valid");
    check("d2_oresp", out_response, 8'h00);
    wait_done("d2_done");

    // Backpressure: hold ready low in OUT for 20 cycles.
    mode = 0;
    out_ready = 1'b0;
    start_run(8'h37, 8'd2);
    wait_valid("e_valid");
    held_c = out_challenge;
    held_r = out_response;
    check("e_ochal", held_c, 8'h37);
    check("e_oresp", held_r, 8'h37);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!out_valid || out_challenge !== held_c || out_response !== held_r ||
          pulse_o || challenge_o !== 8'h37) bad++;
    end
    check("e_stable", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    wait_valid("e_valid2");
    check("e_ochal2", out_challenge, 8'h6E);
    wait_done("e_done");

    // Reset in the middle of a HIGH phase.
    start_run(8'h01, 8'd3);
    k = 0;
    while (!pulse_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("f_in_high", pulse_o, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("f_rst");

    // Start while busy is ignored.
    start_run(8'h01, 8'd1);
    repeat (3) @(negedge clk);
    start_run(8'hAA, 8'd3);
    wait_valid("f_valid");
    check("f_ochal", out_challenge, 8'h01);
    wait_done("f_done");
    @(negedge clk);
    check("f_idle_after", busy, 0);

    // Fresh start runs normally.
    start_run(8'h80, 8'd1);
    wait_valid("g_valid");
    check("g_ochal", out_challenge, 8'h80);
    wait_done("g_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
